// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU result port, load-return handshake,
// register-file write port and issue-stage status.
interface wb_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;

    logic            ld_valid;
    logic            ld_ready;
    logic [4:0]      ld_rd;
    logic [XLEN-1:0] ld_data;
    logic [2:0]      ld_funct3;
    logic [1:0]      ld_addr_lo;

    logic [4:0]      rc;
    logic [XLEN-1:0] wd;
    logic            we;
    logic [31:0]     pend_mask;
    logic            alu_stall;
    logic            err;

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
        output ld_ready,
        output rc, wd, we, pend_mask, alu_stall, err
    );

    // Pipeline / memory / register-file side
    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data, ld_funct3, ld_addr_lo,
        input  ld_ready,
        input  rc, wd, we, pend_mask, alu_stall, err
    );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results with extended load data
// buffered in a small FIFO, with a pending-load scoreboard and starvation stall.
module wb_arbiter #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned STARVE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AGE_W = (STARVE > 0) ? $clog2(STARVE + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } ld_entry_t;

    ld_entry_t        mem_q [DEPTH];
    ld_entry_t        mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             stall_q, stall_d;
    logic [4:0]       rc_q, rc_d;
    logic [XLEN-1:0]  wd_q, wd_d;
    logic             we_q, we_d;
    logic [31:0]      pend_q, pend_d;
    logic             err_q, err_d;

    logic push, pop, non_empty, sel_alu;

    // Byte/halfword extraction of the aligned word, applied before buffering
    function automatic logic [XLEN-1:0] extract(input logic [2:0] f3,
                                                input logic [1:0] off,
                                                input logic [XLEN-1:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  return {{(XLEN-8){b[7]}}, b};
            3'b001:  return {{(XLEN-16){h[15]}}, h};
            3'b010:  return w;
            3'b100:  return XLEN'(b);
            3'b101:  return XLEN'(h);
            default: return '0;
        endcase
    endfunction

    assign bus.ld_ready = rst_n && (count_q < CNT_W'(DEPTH));

    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rc_d     = rc_q;
        wd_d     = wd_q;
        we_d     = 1'b0;

        non_empty = (count_q != '0);
        push      = bus.ld_valid && bus.ld_ready;
        // A starved head outranks the ALU; otherwise the ALU wins
        pop       = non_empty && (stall_q || !bus.alu_valid);
        sel_alu   = bus.alu_valid && !(stall_q && non_empty);

        if (sel_alu) begin
            rc_d = bus.alu_rd;
            wd_d = bus.alu_data;
            we_d = (bus.alu_rd != 5'd0);
        end else if (pop) begin
            rc_d = mem_q[rd_ptr_q].rd;
            wd_d = mem_q[rd_ptr_q].data;
            we_d = (mem_q[rd_ptr_q].rd != 5'd0);
        end

        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + PTR_W'(1);
        end
        if (push) begin
            mem_d[wr_ptr_q].rd   = bus.ld_rd;
            mem_d[wr_ptr_q].data = extract(bus.ld_funct3, bus.ld_addr_lo, bus.ld_data);
            vld_d[wr_ptr_q]      = 1'b1;
            wr_ptr_d             = wr_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        if (pop || !non_empty) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + AGE_W'(1);
        end else begin
            age_d = age_q;
        end
        stall_d = (age_d >= AGE_W'(STARVE));

        err_d = err_q || (bus.alu_valid && stall_q && non_empty);

        // Scoreboard reflects the FIFO contents after this cycle's push/pop
        pend_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (vld_d[PTR_W'(i)]) begin
                pend_d[mem_d[PTR_W'(i)].rd] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
            stall_q  <= 1'b0;
            rc_q     <= '0;
            wd_q     <= '0;
            we_q     <= 1'b0;
            pend_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            age_q    <= age_d;
            stall_q  <= stall_d;
            rc_q     <= rc_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
            pend_q   <= pend_d;
            err_q    <= err_d;
        end
    end

    assign bus.rc        = rc_q;
    assign bus.wd        = wd_q;
    assign bus.we        = we_q;
    assign bus.pend_mask = pend_q;
    assign bus.alu_stall = stall_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: extraction vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_wb_arbiter;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 2;
    localparam int unsigned STARVE = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.XLEN(XLEN)) bus();

    wb_arbiter #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE(STARVE)) u_dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int passed = 0;
    int total  = 0;

    // Reference model state: what the outputs should show after the last edge
    logic [4:0]  mq_rd [$];
    logic [31:0] mq_wd [$];
    int          m_age;
    bit          m_stall, m_err, m_we;
    logic [4:0]  m_rc;
    logic [31:0] m_wd;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] data;
        logic [31:0] exp;
    } ext_vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        else passed++;
    endtask

    function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] d);
        int unsigned o, b, h;
        o = 32'(off);
        b = (d >> (8 * o)) & 32'hFF;
        h = (d >> (16 * (o / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd2:    return d;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_pend();
        logic [31:0] m = 32'd0;
        foreach (mq_rd[i]) if (mq_rd[i] != 5'd0) m = m | (32'd1 << mq_rd[i]);
        return m;
    endfunction

    task automatic model_clear();
        mq_rd.delete();
        mq_wd.delete();
        m_age = 0; m_stall = 0; m_err = 0; m_we = 0; m_rc = '0; m_wd = '0;
    endtask

    // One clock of the writeback rules, using the inputs currently applied
    task automatic model_step();
        int n = mq_rd.size();
        bit push = bus.ld_valid && (n < int'(DEPTH));
        bit pop = 0, alu = 0;
        if (m_stall && n > 0) pop = 1;
        else if (bus.alu_valid) alu = 1;
        else if (n > 0) pop = 1;
        if (bus.alu_valid && m_stall && n > 0) m_err = 1;
        m_we = 0;
        if (alu) begin
            m_rc = bus.alu_rd; m_wd = bus.alu_data; m_we = (bus.alu_rd != 5'd0);
        end else if (pop) begin
            m_rc = mq_rd.pop_front(); m_wd = mq_wd.pop_front(); m_we = (m_rc != 5'd0);
        end
        if (pop || n == 0) m_age = 0;
        else if (m_age < int'(STARVE)) m_age++;
        m_stall = (m_age >= int'(STARVE));
        if (push) begin
            mq_rd.push_back(bus.ld_rd);
            mq_wd.push_back(ref_extract(bus.ld_funct3, bus.ld_addr_lo, bus.ld_data));
        end
    endtask

    task automatic check_outputs();
        chk("we", 32'(bus.we), 32'(m_we));
        if (m_we) begin
            chk("rc", 32'(bus.rc), 32'(m_rc));
            chk("wd", bus.wd, m_wd);
        end
        chk("ld_ready", 32'(bus.ld_ready), 32'(mq_rd.size() < int'(DEPTH)));
        chk("pend_mask", bus.pend_mask, ref_pend());
        chk("alu_stall", 32'(bus.alu_stall), 32'(m_stall));
        chk("err", 32'(bus.err), 32'(m_err));
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle_inputs();
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.ld_valid = 0; bus.ld_rd = '0; bus.ld_data = '0;
        bus.ld_funct3 = '0; bus.ld_addr_lo = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(bus.we), 32'd0);
        chk({tag, "_rc"}, 32'(bus.rc), 32'd0);
        chk({tag, "_wd"}, bus.wd, 32'd0);
        chk({tag, "_pend"}, bus.pend_mask, 32'd0);
        chk({tag, "_stall"}, 32'(bus.alu_stall), 32'd0);
        chk({tag, "_err"}, 32'(bus.err), 32'd0);
        chk({tag, "_ld_ready"}, 32'(bus.ld_ready), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_clear();
        check_reset_outputs("rst_async");
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
    endtask

    task automatic push_load(input logic [4:0] rd, input logic [2:0] f3,
                             input logic [1:0] off, input logic [31:0] d);
        bus.ld_valid = 1; bus.ld_rd = rd; bus.ld_funct3 = f3;
        bus.ld_addr_lo = off; bus.ld_data = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        ext_vec_t vecs [12];
        int n;

        vecs[0]  = '{3'b000, 2'd3, 32'h80FF7F01, 32'hFFFFFF80};
        vecs[1]  = '{3'b100, 2'd1, 32'h80FF7F01, 32'h0000007F};
        vecs[2]  = '{3'b001, 2'd2, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[3]  = '{3'b101, 2'd0, 32'h80FF7F01, 32'h00007F01};
        vecs[4]  = '{3'b010, 2'd0, 32'h80FF7F01, 32'h80FF7F01};
        vecs[5]  = '{3'b000, 2'd0, 32'h80FF7F01, 32'h00000001};
        vecs[6]  = '{3'b100, 2'd3, 32'h80FF7F01, 32'h00000080};
        vecs[7]  = '{3'b101, 2'd2, 32'h80FF7F01, 32'h000080FF};
        vecs[8]  = '{3'b001, 2'd3, 32'h80FF7F01, 32'hFFFF80FF};
        vecs[9]  = '{3'b011, 2'd0, 32'h80FF7F01, 32'h00000000};
        vecs[10] = '{3'b110, 2'd1, 32'h80FF7F01, 32'h00000000};
        vecs[11] = '{3'b111, 2'd2, 32'h80FF7F01, 32'h00000000};

        idle_inputs();
        do_reset();

        // ALU write appears one cycle later
        bus.alu_valid = 1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
        step();
        chk("alu_we", 32'(bus.we), 32'd1);
        chk("alu_rc", 32'(bus.rc), 32'd5);
        chk("alu_wd", bus.wd, 32'h1234);
        idle_inputs();
        step();

        // Extraction table: push into empty FIFO, write lands two edges later
        foreach (vecs[i]) begin
            push_load(5'd9, vecs[i].f3, vecs[i].off, vecs[i].data);
            step();
            idle_inputs();
            step();
            chk($sformatf("ext%0d_we", i), 32'(bus.we), 32'd1);
            chk($sformatf("ext%0d_wd", i), bus.wd, vecs[i].exp);
        end

        // Two loads while the ALU keeps the port busy -> starvation stall
        bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'hA5A5;
        push_load(5'd3, 3'b010, 2'd0, 32'h333);
        step();
        push_load(5'd4, 3'b010, 2'd0, 32'h444);
        step();
        bus.ld_valid = 0;
        chk("full_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("full_pend", bus.pend_mask, 32'h18);
        n = 0;
        while (!bus.alu_stall && n < 10) begin
            step();
            n++;
        end
        chk("stall_wait_cycles", 32'(n), 32'd3);
        step();
        chk("forced_pop_we", 32'(bus.we), 32'd1);
        chk("forced_pop_rc", 32'(bus.rc), 32'd3);
        chk("forced_pop_wd", bus.wd, 32'h333);
        chk("forced_pop_pend", bus.pend_mask, 32'h10);
        chk("drop_err", 32'(bus.err), 32'd1);
        chk("stall_fall", 32'(bus.alu_stall), 32'd0);
        idle_inputs();
        step();
        chk("second_pop_rc", 32'(bus.rc), 32'd4);
        chk("second_pop_pend", bus.pend_mask, 32'd0);
        repeat (3) step();
        chk("err_sticky", 32'(bus.err), 32'd1);
        do_reset();

        // rd = 0 from both sources never writes and never marks the scoreboard
        bus.alu_valid = 1; bus.alu_rd = 5'd0; bus.alu_data = 32'hDEAD;
        step();
        chk("alu_rd0_we", 32'(bus.we), 32'd0);
        idle_inputs();
        push_load(5'd0, 3'b010, 2'd0, 32'hBEEF);
        step();
        chk("ld_rd0_pend", bus.pend_mask, 32'd0);
        idle_inputs();
        step();
        chk("ld_rd0_we", 32'(bus.we), 32'd0);
        chk("ld_rd0_popped", 32'(bus.ld_ready), 32'd1);
        step();

        // Reset with a full FIFO discards everything
        bus.alu_valid = 1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
        push_load(5'd3, 3'b010, 2'd0, 32'h1);
        step();
        push_load(5'd4, 3'b010, 2'd0, 32'h2);
        step();
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("midrst_pend", bus.pend_mask, 32'd0);
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("post_rst_we%0d", k), 32'(bus.we), 32'd0);
        end

        // Random traffic; the issue stage honours alu_stall
        for (int c = 0; c < 500; c++) begin
            bus.alu_valid = ($urandom_range(0, 9) < 7) && !m_stall;
            bus.alu_rd = 5'($urandom_range(0, 31));
            bus.alu_data = $urandom;
            bus.ld_valid = ($urandom_range(0, 9) < 6);
            bus.ld_rd = 5'($urandom_range(0, 31));
            bus.ld_data = $urandom;
            bus.ld_funct3 = 3'($urandom_range(0, 7));
            bus.ld_addr_lo = 2'($urandom_range(0, 3));
            step();
        end
        chk("random_no_err", 32'(bus.err), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
